// File: rtl/cms_frame_packer_if.sv
// Byte-capture to word-consumer bus for cms_frame_packer.
// master = packer side, slave = capture stage / consumer side.
interface cms_frame_packer_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             frame_done_i;
    logic             frame_err_i;
    logic [15:0]      word_o;
    logic             word_last_o;
    logic             word_valid_o;
    logic             word_ready_i;
    logic             overflow_o;
    logic             frame_abort_o;
    logic [LVL_W-1:0] fifo_level_o;

    modport master (
        input  byte_i, byte_valid_i, frame_done_i, frame_err_i, word_ready_i,
        output word_o, word_last_o, word_valid_o, overflow_o, frame_abort_o, fifo_level_o
    );

    modport slave (
        output byte_i, byte_valid_i, frame_done_i, frame_err_i, word_ready_i,
        input  word_o, word_last_o, word_valid_o, overflow_o, frame_abort_o, fifo_level_o
    );
endinterface

// File: rtl/cms_frame_packer.sv
// Packs captured bytes big-endian into 16-bit words with a frame-last flag, buffered in a show-ahead FIFO.
// Optional frame trailer {8'hC5, byte sum} enabled by defining CMS_PACK_CHECKSUM_EN.
module cms_frame_packer #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cms_frame_packer_if.master     bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 17;

    typedef enum logic [2:0] {
        S_HI    = 3'd0,
        S_LO    = 3'd1,
        S_PAD   = 3'd2,
        S_FLUSH = 3'd3
`ifdef CMS_PACK_CHECKSUM_EN
        , S_TRAIL = 3'd4
`endif
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_hi, w_hi_nxt;
    logic [15:0]        r_pend, w_pend_nxt;
    logic               r_pend_vld, w_pend_vld_nxt;
    logic               r_done_d, r_err_d;
    logic               r_abort, w_abort_nxt;
    logic               w_done_rise, w_err_rise;
    logic               w_push, w_push_last;
    logic [15:0]        w_push_word;
`ifdef CMS_PACK_CHECKSUM_EN
    logic [7:0]         r_sum, w_sum_nxt;
`endif

    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_overflow;
    logic               w_full, w_empty, w_pop, w_wr;

    assign w_done_rise = bus.frame_done_i & ~r_done_d;
    assign w_err_rise  = bus.frame_err_i & ~r_err_d;

    // Packing FSM: next state, pending word and push request
    always_comb begin
        w_state_nxt    = r_state;
        w_hi_nxt       = r_hi;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_abort_nxt    = 1'b0;
        w_push         = 1'b0;
        w_push_word    = r_pend;
        w_push_last    = 1'b0;
`ifdef CMS_PACK_CHECKSUM_EN
        w_sum_nxt      = r_sum;
`endif
        if (w_err_rise) begin
            // Abort wins over a simultaneous frame_done; FIFO contents survive
            w_state_nxt    = S_HI;
            w_hi_nxt       = 8'h00;
            w_pend_nxt     = 16'h0000;
            w_pend_vld_nxt = 1'b0;
            w_abort_nxt    = 1'b1;
`ifdef CMS_PACK_CHECKSUM_EN
            w_sum_nxt      = 8'h00;
`endif
        end else begin
            case (r_state)
                S_HI: begin
                    if (bus.byte_valid_i) begin
                        w_hi_nxt    = bus.byte_i;
                        w_state_nxt = S_LO;
`ifdef CMS_PACK_CHECKSUM_EN
                        w_sum_nxt   = r_sum + bus.byte_i;
`endif
                    end else if (w_done_rise) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
                S_LO: begin
                    if (bus.byte_valid_i) begin
                        w_push         = r_pend_vld;
                        w_pend_nxt     = {r_hi, bus.byte_i};
                        w_pend_vld_nxt = 1'b1;
                        w_state_nxt    = S_HI;
`ifdef CMS_PACK_CHECKSUM_EN
                        w_sum_nxt      = r_sum + bus.byte_i;
`endif
                    end else if (w_done_rise) begin
                        w_state_nxt = S_PAD;
                    end
                end
                S_PAD: begin
                    w_push         = r_pend_vld;
                    w_pend_nxt     = {r_hi, 8'h00};
                    w_pend_vld_nxt = 1'b1;
                    w_state_nxt    = S_FLUSH;
                end
                S_FLUSH: begin
                    w_push         = r_pend_vld;
                    w_pend_nxt     = 16'h0000;
                    w_pend_vld_nxt = 1'b0;
`ifdef CMS_PACK_CHECKSUM_EN
                    w_push_last    = 1'b0;
                    w_state_nxt    = S_TRAIL;
`else
                    w_push_last    = 1'b1;
                    w_state_nxt    = S_HI;
`endif
                end
`ifdef CMS_PACK_CHECKSUM_EN
                S_TRAIL: begin
                    w_push      = 1'b1;
                    w_push_word = {8'hC5, r_sum};
                    w_push_last = 1'b1;
                    w_sum_nxt   = 8'h00;
                    w_state_nxt = S_HI;
                end
`endif
                default: w_state_nxt = S_HI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HI;
            r_hi       <= 8'h00;
            r_pend     <= 16'h0000;
            r_pend_vld <= 1'b0;
            r_done_d   <= 1'b0;
            r_err_d    <= 1'b0;
            r_abort    <= 1'b0;
`ifdef CMS_PACK_CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_hi       <= w_hi_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_done_d   <= bus.frame_done_i;
            r_err_d    <= bus.frame_err_i;
            r_abort    <= w_abort_nxt;
`ifdef CMS_PACK_CHECKSUM_EN
            r_sum      <= w_sum_nxt;
`endif
        end
    end

    // Show-ahead FIFO; a push into a full FIFO only lands if a pop frees the slot
    assign w_empty = (r_level == LVL_W'(0));
    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & bus.word_ready_i;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {w_push_last, w_push_word};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.word_o        = r_mem[r_rd_ptr][15:0];
    assign bus.word_last_o   = r_mem[r_rd_ptr][16];
    assign bus.word_valid_o  = ~w_empty;
    assign bus.overflow_o    = r_overflow;
    assign bus.frame_abort_o = r_abort;
    assign bus.fifo_level_o  = r_level;
endmodule

// File: tb/tb_cms_frame_packer.sv
// Scoreboard bench for cms_frame_packer: stimulus queues expected {last,word}, a monitor checks each pop.
module tb_cms_frame_packer;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cms_frame_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();
    cms_frame_packer #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [16:0] sb [$];
    int n_vec  = 0;
    int n_miss = 0;

`ifdef CMS_PACK_CHECKSUM_EN
    localparam logic DATA_LAST = 1'b0;
`else
    localparam logic DATA_LAST = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is compared with the scoreboard head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.word_valid_o === 1'b1 && bus.word_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got %h expected none", {bus.word_last_o, bus.word_o});
            end else begin
                check("word", 32'({bus.word_last_o, bus.word_o}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic end_frame();
        bus.frame_done_i = 1'b1;
        idle(4);
        bus.frame_done_i = 1'b0;
        idle(1);
    endtask

    task automatic exp_w(input logic [15:0] w, input logic l);
        sb.push_back({l, w});
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.word_valid_o) && k < 200) begin
            idle(1);
            k++;
        end
        check({name, "_pending"}, 32'(sb.size()), 32'd0);
        check({name, "_level"}, 32'(bus.fifo_level_o), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word"},  32'(bus.word_o),        32'd0);
        check({name, "_last"},  32'(bus.word_last_o),   32'd0);
        check({name, "_valid"}, 32'(bus.word_valid_o),  32'd0);
        check({name, "_ovf"},   32'(bus.overflow_o),    32'd0);
        check({name, "_abort"}, 32'(bus.frame_abort_o), 32'd0);
        check({name, "_level"}, 32'(bus.fifo_level_o),  32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        bus.frame_done_i = 1'b0;
        bus.frame_err_i  = 1'b0;
        bus.word_ready_i = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        bus.word_ready_i = 1'b1;

        // Even-length frame
        exp_w(16'h1234, 1'b0);
        exp_w(16'h5678, DATA_LAST);
`ifdef CMS_PACK_CHECKSUM_EN
        exp_w(16'hC514, 1'b1);
`endif
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        end_frame();
        wait_drain("even");

        // Odd-length frame, last byte padded
        exp_w(16'hABCD, 1'b0);
        exp_w(16'hEF00, DATA_LAST);
`ifdef CMS_PACK_CHECKSUM_EN
        exp_w(16'hC567, 1'b1);
`endif
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        end_frame();
        wait_drain("odd");

        // Error and done rising together: abort wins
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.frame_err_i  = 1'b1;
        bus.frame_done_i = 1'b1;
        idle(1);
        check("abort_pulse", 32'(bus.frame_abort_o), 32'd1);
        check("abort_level", 32'(bus.fifo_level_o), 32'd0);
        idle(1);
        check("abort_once", 32'(bus.frame_abort_o), 32'd0);
        bus.frame_err_i  = 1'b0;
        bus.frame_done_i = 1'b0;
        idle(2);
        check("abort_empty", 32'(bus.word_valid_o), 32'd0);
        exp_w(16'h4455, DATA_LAST);
`ifdef CMS_PACK_CHECKSUM_EN
        exp_w(16'hC599, 1'b1);
`endif
        send_byte(8'h44); send_byte(8'h55);
        end_frame();
        wait_drain("post_abort");

        // Overflow: 9 words into 8 slots with no consumer
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < 18; i++) send_byte(8'(8'h20 + i));
        end_frame();
        check("ovf_level", 32'(bus.fifo_level_o), 32'd8);
        check("ovf_flag",  32'(bus.overflow_o),   32'd1);
        check("ovf_valid", 32'(bus.word_valid_o), 32'd1);
        check("ovf_head",  32'(bus.word_o),       32'h2021);
        check("ovf_last",  32'(bus.word_last_o),  32'd0);

        // Async reset mid-frame with full FIFO and sticky overflow
        send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        bus.word_ready_i = 1'b1;
        exp_w(16'h9ABC, DATA_LAST);
`ifdef CMS_PACK_CHECKSUM_EN
        exp_w(16'hC556, 1'b1);
`endif
        send_byte(8'h9A); send_byte(8'hBC);
        end_frame();
        wait_drain("after_rst");

        // Full FIFO with simultaneous push and pop
        bus.word_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_w({8'(8'h40 + 2 * k), 8'(8'h41 + 2 * k)}, (k == 9) ? DATA_LAST : 1'b0);
        end
`ifdef CMS_PACK_CHECKSUM_EN
        exp_w(16'hC5BE, 1'b1);
`endif
        for (int i = 0; i < 18; i++) send_byte(8'(8'h40 + i));
        check("full_level", 32'(bus.fifo_level_o), 32'd8);
        check("full_ovf",   32'(bus.overflow_o),   32'd0);
        send_byte(8'h52);
        bus.word_ready_i = 1'b1;
        send_byte(8'h53);
        bus.word_ready_i = 1'b0;
        check("pushpop_level", 32'(bus.fifo_level_o), 32'd8);
        check("pushpop_ovf",   32'(bus.overflow_o),   32'd0);
        bus.word_ready_i = 1'b1;
        end_frame();
        wait_drain("full_drain");
        check("final_ovf", 32'(bus.overflow_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cms_frame_packer.md
CMS_FRAME_PACKER -- requirements
Module: cms_frame_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, word-FIFO entries; SHALL be a power of two, 4..64.
REQ-002 clk  in  1  system clock; all logic SHALL use the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 byte_i  in  8  captured byte from the capture stage data_o.
REQ-005 byte_valid_i  in  1  one-cycle strobe, byte_i valid (capture onebyte_done_o).
REQ-006 frame_done_i  in  1  level, frame complete (capture all_done_o).
REQ-007 frame_err_i  in  1  level, capture timeout (capture error_o).
REQ-008 word_o  out  16  FIFO head word.
REQ-009 word_last_o  out  1  head word is last word of its frame.
REQ-010 word_valid_o  out  1  FIFO not empty.
REQ-011 word_ready_i  in  1  consumer accept; pop SHALL occur when word_valid_o & word_ready_i.
REQ-012 overflow_o  out  1  sticky flag, a word was dropped on full.
REQ-013 frame_abort_o  out  1  one-cycle pulse, frame discarded.
REQ-014 fifo_level_o  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Packing SHALL be big-endian: first byte of a pair to word[15:8], second to word[7:0].
REQ-016 A completed word SHALL be held in a pending register; pending SHALL be pushed (last=0) when the next word completes, so the last flag is known at frame end.
REQ-017 FSM states HI, LO, PAD, FLUSH, TRAIL; reset state HI.
REQ-018 HI: byte_valid_i -> store high byte, go LO; frame_done rise -> FLUSH.
REQ-019 LO: byte_valid_i -> form word, push pending if valid, pending <= word, go HI; frame_done rise -> PAD.
REQ-020 PAD: push pending if valid (last=0); pending <= {high byte, 8'h00}; go FLUSH.
REQ-021 FLUSH: push pending if valid with last=1 (last=0 when checksum enabled); clear pending; go TRAIL if checksum enabled, else HI.
REQ-022 Zero-byte frame SHALL push nothing (checksum disabled) or only the trailer.
REQ-023 byte_valid_i in PAD, FLUSH, TRAIL SHALL be ignored.
REQ-024 frame_done and frame_err SHALL be rising-edge detected via registers reset to 0.
REQ-025 frame_err rise in any state SHALL discard high byte, pending and sum, pulse frame_abort_o one cycle, go HI; it SHALL take priority over a same-cycle frame_done rise; words already in the FIFO SHALL be kept.
REQ-026 FIFO SHALL be show-ahead; a word pushed at edge N SHALL be visible on word_o/word_valid_o after edge N.
REQ-027 Push when full without pop: word dropped, overflow_o set; push and pop in the same cycle when full: both accepted, level unchanged.
REQ-028 Pop when empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 On rst_n low, all outputs SHALL be 0 immediately; FIFO empty; pointers, pending, sum and edge registers cleared; state HI.
REQ-030 Reset mid-frame SHALL discard all partial and stored data without emitting frame_abort_o.

Configuration
REQ-031 Macro CMS_PACK_CHECKSUM_EN defined: sum = modulo-256 sum of frame bytes (pad excluded); TRAIL SHALL push {8'hC5, sum} with last=1, then clear sum and go HI.
REQ-032 Macro undefined: no sum logic and no TRAIL state; last data word SHALL carry last=1.

Verification
REQ-033 Macro off, ready=1: bytes 12,34,56,78 then frame_done -> 0x1234 last=0, 0x5678 last=1.
REQ-034 Macro off: bytes AB,CD,EF then frame_done -> 0xABCD last=0, 0xEF00 last=1; macro on -> 0xABCD, 0xEF00 last=0, 0xC567 last=1.
REQ-035 Bytes 11,22,33 then frame_err and frame_done rising together -> frame_abort_o one-cycle pulse, FIFO empty, next frame 44,55 -> 0x4455 last=1.
REQ-036 FIFO_DEPTH=8, ready=0, 18 bytes then frame_done (macro off) -> level 8, overflow_o=1, 9th (last) word dropped.
REQ-037 FIFO full, ready=1 with a push in the same cycle -> level stays 8, overflow_o stays 0.
REQ-038 rst_n low mid-frame after 3 bytes -> all outputs 0 without a clock edge; next frame packs from a clean high byte.
